// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer for the MIPS core.
// Owns the program counter, issues fetches to instruction memory, holds the
// fetched word in a single output slot for decode, and applies branch/jump
// redirects, stall back-pressure, halt and restart.

module fetch_pc_sequencer #(
  parameter int                    Data_width = 32,
  parameter logic [Data_width-1:0] RESET_PC   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  halt_i,
  output logic                  imem_req_o,
  output logic [Data_width-1:0] imem_addr_o,
  input  logic                  imem_ready_i,
  input  logic [Data_width-1:0] imem_rdata_i,
  input  logic                  stall_i,
  input  logic                  branch_taken_i,
  input  logic                  jump_i,
  input  logic [Data_width-1:0] branch_pc4_i,
  input  logic [15:0]           branch_imm_i,
  input  logic [25:0]           jump_index_i,
  output logic                  instr_valid_o,
  output logic [Data_width-1:0] instr_out_o,
  output logic [Data_width-1:0] instr_pc_o,
  output logic [Data_width-1:0] pc_o
);

  // Sequencer states: waiting for the first start, fetching, or stopped.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHalt  = 2'd2
  } state_e;

  localparam logic [Data_width-1:0] PcStep = Data_width'(4);

  state_e                state_q, state_d;
  logic [Data_width-1:0] pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic [Data_width-1:0] instr_q, instr_d;
  logic [Data_width-1:0] ipc_q, ipc_d;

  logic                  redirect;
  logic                  transfer;
  logic [Data_width-1:0] branch_offset;
  logic [Data_width-1:0] branch_target;
  logic [Data_width-1:0] jump_target;
  logic [Data_width-1:0] redirect_target;

  // Fetch is requested only while fetching and only when the slot can take
  // the returned word: it is empty, or decode is consuming it this cycle.
  always_comb begin
    imem_req_o = (state_q == StFetch) && (!valid_q || !stall_i);
    transfer   = imem_req_o && imem_ready_i;
  end

  // Redirect targets: the word offset is sign-extended and scaled by four,
  // the jump keeps the top nibble of the delay-slot PC. Jump wins over branch.
  // The low two bits are forced to zero so the PC always stays word aligned.
  always_comb begin
    branch_offset   = {{(Data_width-18){branch_imm_i[15]}}, branch_imm_i, 2'b00};
    branch_target   = branch_pc4_i + branch_offset;
    jump_target     = {branch_pc4_i[Data_width-1:28], jump_index_i, 2'b00};
    redirect        = (state_q != StIdle) && (jump_i || branch_taken_i);
    redirect_target = jump_i ? jump_target : branch_target;
    redirect_target = {redirect_target[Data_width-1:2], 2'b00};
  end

  // State transitions: start always (re)enters FETCH and beats a same-cycle
  // halt; halt lets the current cycle's transfer finish before stopping.
  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = StFetch;
    end else begin
      case (state_q)
        StFetch: begin
          if (halt_i) begin
            state_d = StHalt;
          end
        end
        StHalt:  state_d = StHalt;
        default: state_d = StIdle;
      endcase
    end
  end

  // PC and output slot update. Start resets the PC and empties the slot.
  // A redirect loads the target and squashes both the slot and any word
  // arriving this cycle, since that word belongs to the wrong path. Otherwise
  // a transfer fills the slot and advances the PC, an unstalled slot with
  // nothing new drains, and a stalled full slot holds.
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    if (start_i) begin
      pc_d    = RESET_PC;
      valid_d = 1'b0;
    end else if (redirect) begin
      pc_d    = redirect_target;
      valid_d = 1'b0;
    end else if (transfer) begin
      pc_d    = pc_q + PcStep;
      valid_d = 1'b1;
      instr_d = imem_rdata_i;
      ipc_d   = pc_q;
    end else if (!stall_i) begin
      valid_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  // The fetch address is the PC itself; the slot registers drive decode.
  always_comb begin
    imem_addr_o   = pc_q;
    pc_o          = pc_q;
    instr_valid_o = valid_q;
    instr_out_o   = instr_q;
    instr_pc_o    = ipc_q;
  end

endmodule
